// File: rtl/updown_counter.sv
// updown_counter: bidirectional counter with programmable limit/step, load, loop or one-shot halt
module updown_counter #(
    parameter int   WIDTH        = 8,
    parameter int   RST_MAX      = 255,
    parameter logic LOOP         = 1'b1,
    parameter logic RST_DIR_DOWN = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_max,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt_val,
    output logic             o_cnt_done,
    output logic             o_busy,
    output logic             o_at_max,
    output logic             o_at_zero
);
    typedef enum logic {RUN, HALT} state_t;
    localparam logic [WIDTH-1:0] RST_VAL = RST_DIR_DOWN ? WIDTH'(RST_MAX) : '0;
    state_t           state, state_n;
    logic [WIDTH-1:0] cnt_n;
    logic             done_n;
    logic [WIDTH:0]   sum;
    assign sum       = {1'b0, o_cnt_val} + {1'b0, i_step};
    assign o_busy    = state == RUN;
    assign o_at_max  = o_cnt_val == i_max;
    assign o_at_zero = o_cnt_val == '0;
    // next state: load beats enable; range correction before stepping; overshoot is the terminal event
    always_comb begin
        state_n = state;
        cnt_n   = o_cnt_val;
        done_n  = 1'b0;
        if (i_load) begin
            cnt_n   = i_load_val > i_max ? i_max : i_load_val;
            state_n = RUN;
        end else if (i_en && state == RUN) begin
            if (o_cnt_val > i_max) cnt_n = i_max;
            else if (!i_dir) begin
                if (sum <= {1'b0, i_max}) cnt_n = sum[WIDTH-1:0];
                else begin
                    done_n  = 1'b1;
                    cnt_n   = LOOP ? '0 : i_max;
                    state_n = LOOP ? RUN : HALT;
                end
            end else begin
                if (o_cnt_val >= i_step) cnt_n = o_cnt_val - i_step;
                else begin
                    done_n  = 1'b1;
                    cnt_n   = LOOP ? i_max : '0;
                    state_n = LOOP ? RUN : HALT;
                end
            end
        end
    end
    // registers with synchronous reset overriding everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= RUN;
            o_cnt_val  <= RST_VAL;
            o_cnt_done <= 1'b0;
        end else begin
            state      <= state_n;
            o_cnt_val  <= cnt_n;
            o_cnt_done <= done_n;
        end
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed checks of looping, one-shot and down-reset counter instances
module tb_updown_counter;
    logic       clk = 1'b0;
    logic       rst, en, dir, load;
    logic [7:0] step, max, load_val;
    logic [7:0] l_cnt, h_cnt, d_cnt;
    logic       l_done, h_done, d_done, l_busy, h_busy, d_busy;
    logic       l_amax, h_amax, d_amax, l_azero, h_azero, d_azero;
    int         tests = 0;
    int         fails = 0;
    int         lexp[6] = '{1, 2, 3, 0, 1, 2};
    int         hexp[6] = '{1, 2, 3, 3, 3, 3};
    int         hdone[6] = '{0, 0, 0, 1, 0, 0};
    int         hbusy[6] = '{1, 1, 1, 0, 0, 0};

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(8), .RST_MAX(255), .LOOP(1'b1), .RST_DIR_DOWN(1'b0)) u_loop (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_step(step), .i_max(max),
        .i_load(load), .i_load_val(load_val), .o_cnt_val(l_cnt), .o_cnt_done(l_done),
        .o_busy(l_busy), .o_at_max(l_amax), .o_at_zero(l_azero));
    updown_counter #(.WIDTH(8), .RST_MAX(255), .LOOP(1'b0), .RST_DIR_DOWN(1'b0)) u_halt (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_step(step), .i_max(max),
        .i_load(load), .i_load_val(load_val), .o_cnt_val(h_cnt), .o_cnt_done(h_done),
        .o_busy(h_busy), .o_at_max(h_amax), .o_at_zero(h_azero));
    updown_counter #(.WIDTH(8), .RST_MAX(200), .LOOP(1'b1), .RST_DIR_DOWN(1'b1)) u_down (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_step(step), .i_max(max),
        .i_load(load), .i_load_val(load_val), .o_cnt_val(d_cnt), .o_cnt_done(d_done),
        .o_busy(d_busy), .o_at_max(d_amax), .o_at_zero(d_azero));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0;
        step = 8'd0; max = 8'd255; load_val = 8'd0;
        tick();
        check("rst_cnt", l_cnt, 0);
        check("rst_done", l_done, 0);
        check("rst_busy", l_busy, 1);
        check("rst_zero", l_azero, 1);
        check("rst_down_cnt", d_cnt, 200);
        rst = 1'b0;
        max = 8'd3; step = 8'd1; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("s1_loop_cnt", l_cnt, lexp[i]);
            check("s1_loop_done", l_done, lexp[i] == 0);
            check("s1_loop_busy", l_busy, 1);
            check("s1_loop_atmax", l_amax, lexp[i] == 3);
            check("s1_halt_cnt", h_cnt, hexp[i]);
            check("s1_halt_done", h_done, hdone[i]);
            check("s1_halt_busy", h_busy, hbusy[i]);
        end
        max = 8'd10; step = 8'd4; dir = 1'b1; en = 1'b0; load = 1'b1; load_val = 8'd10;
        tick();
        check("s2_load_cnt", h_cnt, 10);
        check("s2_load_busy", h_busy, 1);
        load = 1'b0; en = 1'b1;
        tick();
        check("s2_cnt_a", h_cnt, 6);
        check("s2_loop_a", l_cnt, 6);
        tick();
        check("s2_cnt_b", h_cnt, 2);
        check("s2_done_b", h_done, 0);
        tick();
        check("s2_cnt_c", h_cnt, 0);
        check("s2_done_c", h_done, 1);
        check("s2_busy_c", h_busy, 0);
        check("s2_loop_wrap", l_cnt, 10);
        check("s2_loop_done", l_done, 1);
        tick();
        check("s2_hold_cnt", h_cnt, 0);
        check("s2_hold_done", h_done, 0);
        en = 1'b0; load = 1'b1; load_val = 8'd5;
        tick();
        check("s2_reload_cnt", h_cnt, 5);
        check("s2_reload_busy", h_busy, 1);
        max = 8'd255; step = 8'd200; dir = 1'b0; load_val = 8'd100;
        tick();
        check("s3_load", l_cnt, 100);
        load = 1'b0; en = 1'b1;
        tick();
        check("s3_loop_cnt", l_cnt, 0);
        check("s3_loop_done", l_done, 1);
        check("s3_halt_cnt", h_cnt, 255);
        check("s3_halt_busy", h_busy, 0);
        max = 8'd20; step = 8'd1; en = 1'b0; load = 1'b1; load_val = 8'd9;
        tick();
        check("s4_load", l_cnt, 9);
        load = 1'b0; max = 8'd5;
        #1;
        check("s4_atmax_comb", l_amax, 0);
        en = 1'b1;
        tick();
        check("s4_clamp_cnt", l_cnt, 5);
        check("s4_clamp_done", l_done, 0);
        check("s4_clamp_atmax", l_amax, 1);
        tick();
        check("s4_wrap_cnt", l_cnt, 0);
        check("s4_wrap_done", l_done, 1);
        check("s4_halt_cnt", h_cnt, 5);
        check("s4_halt_busy", h_busy, 0);
        rst = 1'b1; load = 1'b1; load_val = 8'd7; en = 1'b1;
        tick();
        check("s5_rst_cnt", l_cnt, 0);
        check("s5_rst_done", l_done, 0);
        check("s5_rst_halt_busy", h_busy, 1);
        check("s5_rst_down_cnt", d_cnt, 200);
        rst = 1'b0; max = 8'd20; load_val = 8'd255;
        tick();
        check("s5_clip_cnt", l_cnt, 20);
        check("s5_clip_done", l_done, 0);
        check("s5_clip_down", d_cnt, 20);
        load = 1'b0; step = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s6_step0_cnt", l_cnt, 20);
            check("s6_step0_done", l_done, 0);
        end
        max = 8'd0; step = 8'd1;
        tick();
        check("s6_max0_clamp", l_cnt, 0);
        check("s6_max0_nodone", l_done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_max0_cnt", l_cnt, 0);
            check("s6_max0_done", l_done, 1);
            check("s6_max0_zero", l_azero, 1);
        end
        en = 1'b0;
        tick();
        check("s6_idle_done", l_done, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
